// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: commits good frames at tlast and rolls back bad or overflowed ones.
// Optional per-frame length cap enabled by defining ETH_RX_FIFO_MAX_LEN_EN.
module eth_rx_frame_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  status_good_frame,
    output logic                  status_bad_frame,
    output logic                  status_overflow
);

    localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_FILL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_DROP
    } wr_state_e;

    logic [DATA_WIDTH:0] mem [DEPTH];

    wr_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic                good_q, good_d;
    logic                bad_q, bad_d;
    logic                ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                m_valid_q;
    logic                m_last_q;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic frame_done;
    logic len_over;

    assign full  = (wr_ptr_q - rd_ptr_q) == FULL_FILL;
    assign empty = (rd_ptr_q == commit_ptr_q);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        ovf_d        = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                WR_IDLE, WR_ACTIVE: begin
                    if (full || len_over) begin
                        wr_ptr_d = commit_ptr_q;
                        ovf_d    = 1'b1;
                        state_d  = s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = WR_ACTIVE;
                        if (s_axis_tlast) begin
                            state_d = WR_IDLE;
                            if (s_axis_tuser) begin
                                wr_ptr_d = commit_ptr_q;
                                bad_d    = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                good_d       = 1'b1;
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) state_d = WR_IDLE;
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    assign frame_done = ovf_d || (wr_en && s_axis_tlast);

`ifdef ETH_RX_FIFO_MAX_LEN_EN
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    logic [15:0] len_q, len_d;

    // The beat that would push the length past the cap is the one rejected.
    assign len_over = (len_q >= MAX_LEN);

    always_comb begin
        len_d = len_q;
        if (frame_done)                   len_d = '0;
        else if (wr_en && len_q != '1)    len_d = len_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) len_q <= '0;
        else     len_q <= len_d;
    end
`else
    logic unused_max_len;

    assign len_over       = 1'b0;
    assign unused_max_len = ^MAX_FRAME_LEN;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            ovf_q        <= ovf_d;
        end
    end

    // NOTE: the RAM array has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // The synchronous RAM read lands directly in the output register.
    assign rd_en = !empty && (!m_valid_q || m_axis_tready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (rd_en) begin
            rd_ptr_q               <= rd_ptr_q + 1'b1;
            {m_last_q, m_data_q}   <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            m_valid_q              <= 1'b1;
        end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_axis_tdata      = m_data_q;
    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_tlast      = m_last_q;
    assign status_good_frame = good_q;
    assign status_bad_frame  = bad_q;
    assign status_overflow   = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Randomized self-checking bench for eth_rx_frame_fifo against a frame-level scoreboard model.
// Small RAM (128 entries) and a 100-byte cap make overflow and the optional length limit reachable.
module tb_eth_rx_frame_fifo;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 2 ** AW;
    localparam int MAXL  = 100;

    typedef enum int {OUT_GOOD, OUT_BAD, OUT_OVF} outcome_e;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          st_good;
    logic          st_bad;
    logic          st_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    int n_good = 0, n_bad = 0, n_ovf = 0;
    int exp_good = 0, exp_bad = 0, exp_ovf = 0;
    int commit_cnt = 0;
    int ready_mode = 0;

    logic [DW:0] exp_q[$];

    eth_rx_frame_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MAX_FRAME_LEN(MAXL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_tdata),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .m_axis_tdata     (m_tdata),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .status_good_frame(st_good),
        .status_bad_frame (st_bad),
        .status_overflow  (st_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard compare on handshake, hold check while stalled, pulse counting.
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (st_good) n_good++;
            if (st_bad)  n_bad++;
            if (st_ovf)  n_ovf++;
            if (stalled) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", 32'(m_tdata), 32'(held_data));
                check("hold_last", 32'(m_tlast), 32'(held_last));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 32'(m_tvalid), 32'd0);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("out_beat", 32'({m_tlast, m_tdata}), 32'(e));
                end
            end
            stalled   = m_tvalid && !m_tready;
            held_data = m_tdata;
            held_last = m_tlast;
        end
    end

    function automatic outcome_e predict(input int len, input bit bad, input int space);
        if (len > space) return OUT_OVF;
`ifdef ETH_RX_FIFO_MAX_LEN_EN
        if (len > MAXL) return OUT_OVF;
`endif
        if (bad) return OUT_BAD;
        return OUT_GOOD;
    endfunction

    task automatic drive_beat(input logic [DW-1:0] d, input logic last, input logic user);
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    // space: RAM entries known to be free when the frame starts.
    task automatic send_frame(input int len, input bit bad, input int space, input bit gaps);
        logic [DW:0] bytes[$];
        outcome_e    oc;
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            logic          last;
            if (gaps && $urandom_range(0, 7) == 0) begin
                s_tdata = DW'($urandom);
                @(posedge clk);
                #1;
            end
            d    = DW'($urandom);
            last = (i == len - 1);
            drive_beat(d, last, last ? bad : 1'($urandom_range(0, 1)));
            bytes.push_back({last, d});
        end
        oc = predict(len, bad, space);
        case (oc)
            OUT_GOOD: begin
                exp_good++;
                commit_cnt += len;
                foreach (bytes[i]) exp_q.push_back(bytes[i]);
            end
            OUT_BAD: exp_bad++;
            default: exp_ovf++;
        endcase
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || m_tvalid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_good_cnt"}, n_good, exp_good);
        check({tag, "_bad_cnt"}, n_bad, exp_bad);
        check({tag, "_ovf_cnt"}, n_ovf, exp_ovf);
        check({tag, "_commit_ptr"}, 32'(dut.commit_ptr_q), commit_cnt % (2 * DEPTH));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_status"}, 32'({st_good, st_bad, st_ovf}), 32'd0);
        check({tag, "_wr_ptr"}, 32'(dut.wr_ptr_q), 32'd0);
        check({tag, "_rd_ptr"}, 32'(dut.rd_ptr_q), 32'd0);
        check({tag, "_commit_ptr"}, 32'(dut.commit_ptr_q), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // 64-byte good frame with tready high; tvalid must rise exactly two cycles after tlast.
        ready_mode = 1;
        @(posedge clk);
        #1;
        send_frame(64, 1'b0, DEPTH, 1'b0);
        @(negedge clk);
        check("latency_n1", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        check("latency_n2", 32'(m_tvalid), 32'd1);
        wait_drain();
        check_counters("t1");

        // Bad frame: nothing emitted, commit pointer untouched.
        send_frame(64, 1'b1, DEPTH, 1'b0);
        wait_drain();
        check_counters("t2");

        // RAM-full overflow with the output stalled, then release and a short follow-up frame.
        ready_mode = 0;
        send_frame(80, 1'b0, DEPTH, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_frame(80, 1'b0, DEPTH - 79, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_counters("t3a");
        ready_mode = 1;
        wait_drain();
        send_frame(20, 1'b0, DEPTH, 1'b0);
        wait_drain();
        check_counters("t3b");

        // Good / bad / good back to back under random backpressure.
        ready_mode = 2;
        send_frame(int'($urandom_range(1, 40)), 1'b0, DEPTH, 1'b0);
        send_frame(int'($urandom_range(1, 40)), 1'b1, DEPTH - 40, 1'b0);
        send_frame(int'($urandom_range(1, 40)), 1'b0, DEPTH - 80, 1'b0);
        wait_drain();
        check_counters("t4");

        // Reset in the middle of a frame with a committed frame still buffered.
        ready_mode = 0;
        send_frame(30, 1'b0, DEPTH, 1'b0);
        for (int i = 0; i < 10; i++) drive_beat(DW'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        commit_cnt = 0;
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        ready_mode = 2;
        send_frame(50, 1'b0, DEPTH, 1'b1);
        wait_drain();
        check_counters("t5");

        // Length boundaries: cap (when compiled in) and RAM depth.
        ready_mode = 1;
        send_frame(MAXL, 1'b0, DEPTH, 1'b0);
        wait_drain();
        send_frame(MAXL + 1, 1'b0, DEPTH, 1'b0);
        wait_drain();
        send_frame(DEPTH, 1'b0, DEPTH, 1'b0);
        wait_drain();
        send_frame(DEPTH + 1, 1'b0, DEPTH, 1'b0);
        wait_drain();
        send_frame(1, 1'b0, DEPTH, 1'b0);
        wait_drain();
        check_counters("t6");

        // Randomized rounds of three frames; total length per round stays below the RAM depth.
        for (int r = 0; r < 20; r++) begin
            int used;
            used = 0;
            ready_mode = 2;
            for (int k = 0; k < 3; k++) begin
                int len;
                len = int'($urandom_range(1, 40));
                send_frame(len, ($urandom_range(0, 3) == 0), DEPTH - used, 1'b1);
                used += len;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_drain();
        end
        check_counters("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
